// File: rtl/mag16_sched_pkg.sv
// Shared constants and types for the mag16 round-robin scheduler.
package mag16_sched_pkg;

    localparam int MAG_W   = 16;
    localparam int MAG_LAT = 12;
    localparam int ID_W    = 3;

    // One tag-line stage: occupancy plus the owning channel.
    typedef struct packed {
        logic            v;
        logic [ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/mag16_sched_rr_arb.sv
// Combinational round-robin arbiter: the first requester at or after ptr wins.
module rr_arb
    import mag16_sched_pkg::*;
#(
    parameter int NCH = 4
) (
    input  logic [NCH-1:0]  req_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic            gnt_v_o,
    output logic [ID_W-1:0] gnt_id_o
);

    logic [2*NCH-1:0] dbl;
    logic [NCH-1:0]   rot;
    logic [ID_W-1:0]  off;
    logic [ID_W:0]    sum;

    // rot[i] is the request of channel (ptr+i) mod NCH.
    always_comb begin
        dbl = {req_i, req_i} >> ptr_i;
        rot = dbl[NCH-1:0];
        off = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = ID_W'(i);
            end
        end
        sum = {1'b0, ptr_i} + {1'b0, off};
        if (sum >= (ID_W+1)'(NCH)) begin
            sum = sum - (ID_W+1)'(NCH);
        end
        gnt_v_o  = |req_i;
        gnt_id_o = sum[ID_W-1:0];
    end

endmodule

// File: rtl/mag16_sched.sv
// Shares one external mag16 pipeline among NCH requesters and routes each
// returned magnitude back to its channel via a tag line matched to the latency.
module mag16_sched
    import mag16_sched_pkg::*;
#(
    parameter int NCH = 4,
    parameter int LAT = MAG_LAT,
    parameter int W   = MAG_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH*W-1:0] ch_x,
    input  logic [NCH*W-1:0] ch_y,
    input  logic [NCH-1:0] ch_iv,
    output logic [W-1:0]   ch_m,
    output logic [NCH-1:0] ch_ov,
    output logic [W-1:0]   mx,
    output logic [W-1:0]   my,
    output logic           miv,
    input  logic [W-1:0]   mm,
    input  logic           mov,
    input  logic           clr,
    output logic [NCH-1:0] ovr,
    output logic           err
);

    localparam int BW = $clog2(LAT + 1);

    logic [NCH-1:0]  pend_q, pend_d;
    logic [W-1:0]    hx_q [NCH];
    logic [W-1:0]    hy_q [NCH];
    logic [ID_W-1:0] ptr_q, ptr_d;

    logic            gnt_v;
    logic [ID_W-1:0] gnt_id;
    logic [NCH-1:0]  gnt_oh;
    logic [W-1:0]    iss_x, iss_y;

    logic            miv_q;
    logic [W-1:0]    mx_q, my_q;
    logic [ID_W-1:0] iss_id_q;
    tag_t            tag_q [LAT];

    logic [W-1:0]    ch_m_q;
    logic [NCH-1:0]  ch_ov_q, ch_ov_d;
    logic [NCH-1:0]  ovr_q, ovr_d, ovr_set;
    logic            err_q, err_d, err_set;
    logic [BW-1:0]   blank_q;
    logic            live, tag_hit, ret;

    rr_arb #(.NCH(NCH)) u_arb (
        .req_i    (pend_q),
        .ptr_i    (ptr_q),
        .gnt_v_o  (gnt_v),
        .gnt_id_o (gnt_id)
    );

    always_comb begin
        gnt_oh = gnt_v ? (NCH'(1) << gnt_id) : '0;
        iss_x  = '0;
        iss_y  = '0;
        for (int k = 0; k < NCH; k++) begin
            if (gnt_oh[k]) begin
                iss_x = hx_q[k];
                iss_y = hy_q[k];
            end
        end
        // A granted channel that strobes again keeps pend set without overrun.
        pend_d  = ch_iv | (pend_q & ~gnt_oh);
        ovr_set = ch_iv & pend_q & ~gnt_oh;
        ovr_d   = (ovr_q & ~{NCH{clr}}) | ovr_set;
        if (!gnt_v) begin
            ptr_d = ptr_q;
        end else if (gnt_id == ID_W'(NCH - 1)) begin
            ptr_d = '0;
        end else begin
            ptr_d = gnt_id + 1'b1;
        end
    end

    // mov is ignored while blank_q counts down after reset release.
    always_comb begin
        live    = (blank_q == '0);
        tag_hit = tag_q[LAT-1].v;
        ret     = live & mov & tag_hit;
        ch_ov_d = ret ? (NCH'(1) << tag_q[LAT-1].id) : '0;
        err_set = live & (mov != tag_hit);
        err_d   = (err_q & ~clr) | err_set;
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NCH; k++) begin
            if (ch_iv[k]) begin
                hx_q[k] <= ch_x[k*W +: W];
                hy_q[k] <= ch_y[k*W +: W];
            end
        end
    end

    // The tag line is fed from the registered issue so its last stage lines
    // up with mov, which trails miv by LAT clocks.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q   <= '0;
            ptr_q    <= '0;
            miv_q    <= 1'b0;
            mx_q     <= '0;
            my_q     <= '0;
            iss_id_q <= '0;
            for (int s = 0; s < LAT; s++) begin
                tag_q[s] <= '0;
            end
            ch_m_q   <= '0;
            ch_ov_q  <= '0;
            ovr_q    <= '0;
            err_q    <= 1'b0;
            blank_q  <= BW'(LAT);
        end else begin
            pend_q   <= pend_d;
            ptr_q    <= ptr_d;
            miv_q    <= gnt_v;
            iss_id_q <= gnt_id;
            if (gnt_v) begin
                mx_q <= iss_x;
                my_q <= iss_y;
            end
            tag_q[0] <= '{v: miv_q, id: iss_id_q};
            for (int s = 1; s < LAT; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
            if (ret) begin
                ch_m_q <= mm;
            end
            ch_ov_q  <= ch_ov_d;
            ovr_q    <= ovr_d;
            err_q    <= err_d;
            if (blank_q != '0) begin
                blank_q <= blank_q - 1'b1;
            end
        end
    end

    assign mx    = mx_q;
    assign my    = my_q;
    assign miv   = miv_q;
    assign ch_m  = ch_m_q;
    assign ch_ov = ch_ov_q;
    assign ovr   = ovr_q;
    assign err   = err_q;

endmodule
